mem_pipe_arbiter: RTL and testbench
===================================

Name: mem_pipe_arbiter

Overview:
- Shares the single 4-stage memory pipeline (M0–M3, then writeback) between two requesters: port 0, the load/store issue queue, and port 1, the auxiliary/debug memory port.
- Arbitrates round-robin and registers the winning operation onto the is_m0_* issue bus.
- Tracks in-flight loads in a scoreboard and holds any request whose source register is still pending.
- Provides a flush/drain sequence used before pipeline reconfiguration.

Parameters:
- PIPE_DEPTH, 5, scoreboard slots: issue register plus M0..M3.
- FU_MEM, 2, functional-unit code driven on is_m0_functionalunit when an op is issued.
- FU_NONE, 0, functional-unit code driven when idle. Any code other than FU_MEM makes the memory pipe insert a bubble.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request N valid (N=0,1).
- reqN_ready  out  1  request N accepted this cycle. Combinational.
- reqN_readmem, reqN_writemem, reqN_writereg  in  1 each  operation flags.
- reqN_rega, reqN_regdestv, reqN_imedext  in  32 each  base value, store data, offset.
- reqN_regdest  in  5  destination register.
- reqN_srca, reqN_srcv  in  5 each  register indices of base and store data, used for hazard checks.
- is_m0_functionalunit  out  2  FU_MEM or FU_NONE.
- is_m0_readmem, is_m0_writemem, is_m0_writereg  out  1 each.
- is_m0_rega, is_m0_regdestv, is_m0_imedext  out  32 each.
- is_m0_regdest  out  5.
- flush  in  1  drain request (level).
- flush_done  out  1  pipe empty while flushing.
- busy  out  1  any scoreboard slot valid.

Behaviour:
Reset:
- Sync, active-high.
- All is_m0_* outputs = 0; functionalunit = FU_NONE.
- Scoreboard cleared; last_grant = 1, so port 0 wins first.
- FSM = RUN; flush_done = 0; busy = 0.
- Reset asserted mid-operation discards all in-flight tracking. Downstream pipe is reset by the same signal.

Eligibility:
- Request N is eligible when valid, FSM = RUN and there is no hazard.
- Hazard: some scoreboard slot has valid & writereg & regdest != 0, and that regdest equals srca, or equals srcv when writemem = 1.
- Register 0 never causes a hazard.

Arbitration:
- Both eligible → the port != last_grant wins. One eligible → it wins.
- reqN_ready = 1 only for the winner. Transfer occurs when valid & ready.
- last_grant updates on every transfer.
- A requester must hold its fields stable while valid & !ready.

Issue register:
- On transfer, the winner's fields are loaded on the next edge and functionalunit = FU_MEM, so latency from grant to M0 input is 1 cycle.
- With no transfer: functionalunit = FU_NONE, flags = 0, data fields = 0.

Scoreboard:
- PIPE_DEPTH-entry shift register of {valid, writereg, regdest}; shifts every cycle.
- Slot 0 is loaded with the transferring op, or invalid when there is none.
- A load granted in cycle t is visible on m_wb in cycle t+5 and leaves the scoreboard at the edge ending t+5.
- The earliest grant for a dependent request is cycle t+6.
- busy = OR of slot valids.

FSM:
- RUN → DRAIN when flush = 1. No new grants that cycle; both ready = 0.
- DRAIN: ready = 0 for both ports; flush_done = !busy.
- DRAIN → RUN when flush = 0.
- A flush deasserted before the pipe is empty returns to RUN immediately; in-flight ops are not cancelled.

Optional Feature:
- Macro MEM_PIPE_ARB_STATS_EN.
- When defined, adds three 32-bit output counters, each reset to 0 and saturating at 0xFFFF_FFFF:
  - stat_grant0: transfers on port 0.
  - stat_grant1: transfers on port 1.
  - stat_hazard: cycles in which any valid request was blocked by a hazard.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pipe_pkg holds:
  - FU_NONE / FU_MEM constants.
  - mem_req_t struct {readmem, writemem, writereg, rega, regdestv, imedext, regdest, srca, srcv}.
  - arb_state_t enum {RUN, DRAIN}.
- One sub-module, mem_scoreboard: the shift register, hazard compare for two requests, and busy.

Test Plan:
- Reset, then idle for 3 cycles → functionalunit = 0, busy = 0, both ready = 0.
- Both ports request continuously with independent registers for 6 cycles → grants alternate 0,1,0,1,0,1; each issue bus value appears 1 cycle after its grant.
- Port 0 loads r5 (rega = 0x10, imedext = 4) in cycle t; port 1 requests with srca = 5 from t+1 → port 1 ready = 0 through t+5, ready = 1 at t+6. Load writeback shows regdest = 5 at t+5.
- Store with writemem = 1, srcv = 7, while a load to r7 is in flight → held. The same store with srcv = 0 and an r0 "load" in flight → not held.
- flush asserted with 3 ops in flight → ready = 0 immediately; flush_done rises once busy = 0, after 5 cycles; deasserting flush resumes grants the next cycle.
- Assert reset while 2 loads are in flight → busy = 0 and every output = 0 the next cycle; a previously blocked dependent request is granted in the first cycle after reset.

Source files
------------

// File: rtl/mem_pipe_pkg.sv
// Shared types and constants for the memory-pipe arbiter and its scoreboard.
package mem_pipe_pkg;

  localparam logic [1:0] FU_NONE = 2'd0;
  localparam logic [1:0] FU_MEM  = 2'd2;

  typedef struct packed {
    logic        readmem;
    logic        writemem;
    logic        writereg;
    logic [31:0] rega;
    logic [31:0] regdestv;
    logic [31:0] imedext;
    logic [4:0]  regdest;
    logic [4:0]  srca;
    logic [4:0]  srcv;
  } mem_req_t;

  // Only the fields the hazard compare needs.
  typedef struct packed {
    logic       writemem;
    logic [4:0] srca;
    logic [4:0] srcv;
  } hz_src_t;

  typedef struct packed {
    logic       valid;
    logic       writereg;
    logic [4:0] regdest;
  } sb_entry_t;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} arb_state_t;

  // r0 is hardwired, so a write to it never blocks a reader.
  function automatic logic slot_hits(sb_entry_t e, hz_src_t s);
    return e.valid && e.writereg && (e.regdest != 5'd0) &&
           ((e.regdest == s.srca) || (s.writemem && (e.regdest == s.srcv)));
  endfunction

endpackage

// File: rtl/mem_scoreboard.sv
// In-flight writer tracking for the memory pipe: one slot per stage, shifted
// every cycle, with hazard compares for both requesters.
module mem_scoreboard
  import mem_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 5
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      push_writereg,
  input  logic [4:0] push_regdest,
  input  hz_src_t   src0,
  input  hz_src_t   src1,
  output logic      hazard0,
  output logic      hazard1,
  output logic      busy
);

  sb_entry_t slots [PIPE_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) slots[i] <= '0;
    end else begin
      slots[0] <= '{valid: push, writereg: push_writereg, regdest: push_regdest};
      for (int i = 1; i < PIPE_DEPTH; i++) slots[i] <= slots[i-1];
    end
  end

  always_comb begin
    hazard0 = 1'b0;
    hazard1 = 1'b0;
    busy    = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      hazard0 = hazard0 | slot_hits(slots[i], src0);
      hazard1 = hazard1 | slot_hits(slots[i], src1);
      busy    = busy | slots[i].valid;
    end
  end

endmodule

// File: rtl/mem_pipe_arbiter.sv
// Round-robin arbiter feeding the shared memory pipe, with load-use hold and
// flush/drain. Define MEM_PIPE_ARB_STATS_EN to add grant/hazard counters.
module mem_pipe_arbiter
  import mem_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_readmem,
  input  logic        req0_writemem,
  input  logic        req0_writereg,
  input  logic [31:0] req0_rega,
  input  logic [31:0] req0_regdestv,
  input  logic [31:0] req0_imedext,
  input  logic [4:0]  req0_regdest,
  input  logic [4:0]  req0_srca,
  input  logic [4:0]  req0_srcv,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_readmem,
  input  logic        req1_writemem,
  input  logic        req1_writereg,
  input  logic [31:0] req1_rega,
  input  logic [31:0] req1_regdestv,
  input  logic [31:0] req1_imedext,
  input  logic [4:0]  req1_regdest,
  input  logic [4:0]  req1_srca,
  input  logic [4:0]  req1_srcv,
  output logic [1:0]  is_m0_functionalunit,
  output logic        is_m0_readmem,
  output logic        is_m0_writemem,
  output logic        is_m0_writereg,
  output logic [31:0] is_m0_rega,
  output logic [31:0] is_m0_regdestv,
  output logic [31:0] is_m0_imedext,
  output logic [4:0]  is_m0_regdest,
  input  logic        flush,
  output logic        flush_done,
  output logic        busy
`ifdef MEM_PIPE_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_hazard
`endif
);

  mem_req_t   r0, r1;
  arb_state_t state;
  logic       last_grant;
  logic       hazard0, hazard1;
  logic       run_ok, elig0, elig1, grant0, grant1, xfer;

  assign r0 = '{readmem: req0_readmem, writemem: req0_writemem, writereg: req0_writereg,
                rega: req0_rega, regdestv: req0_regdestv, imedext: req0_imedext,
                regdest: req0_regdest, srca: req0_srca, srcv: req0_srcv};
  assign r1 = '{readmem: req1_readmem, writemem: req1_writemem, writereg: req1_writereg,
                rega: req1_rega, regdestv: req1_regdestv, imedext: req1_imedext,
                regdest: req1_regdest, srca: req1_srca, srcv: req1_srcv};

  mem_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb (
    .clock         (clock),
    .reset         (reset),
    .push          (xfer),
    .push_writereg (grant1 ? r1.writereg : r0.writereg),
    .push_regdest  (grant1 ? r1.regdest : r0.regdest),
    .src0          ('{writemem: r0.writemem, srca: r0.srca, srcv: r0.srcv}),
    .src1          ('{writemem: r1.writemem, srca: r1.srca, srcv: r1.srcv}),
    .hazard0       (hazard0),
    .hazard1       (hazard1),
    .busy          (busy)
  );

  // A rising flush blocks grants in the same cycle it is seen.
  assign run_ok = (state == RUN) && !flush;
  assign elig0  = req0_valid && run_ok && !hazard0;
  assign elig1  = req1_valid && run_ok && !hazard1;
  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);
  assign xfer   = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign flush_done = (state == DRAIN) && !busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      last_grant <= 1'b1;
    end else begin
      if (xfer) last_grant <= grant1;
      case (state)
        RUN:     if (flush)  state <= DRAIN;
        DRAIN:   if (!flush) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Issue register: idle cycles drive a zeroed bubble.
  always_ff @(posedge clock) begin
    if (reset || !xfer) begin
      is_m0_functionalunit <= FU_NONE;
      is_m0_readmem        <= 1'b0;
      is_m0_writemem       <= 1'b0;
      is_m0_writereg       <= 1'b0;
      is_m0_rega           <= '0;
      is_m0_regdestv       <= '0;
      is_m0_imedext        <= '0;
      is_m0_regdest        <= '0;
    end else begin
      is_m0_functionalunit <= FU_MEM;
      is_m0_readmem        <= grant1 ? r1.readmem  : r0.readmem;
      is_m0_writemem       <= grant1 ? r1.writemem : r0.writemem;
      is_m0_writereg       <= grant1 ? r1.writereg : r0.writereg;
      is_m0_rega           <= grant1 ? r1.rega     : r0.rega;
      is_m0_regdestv       <= grant1 ? r1.regdestv : r0.regdestv;
      is_m0_imedext        <= grant1 ? r1.imedext  : r0.imedext;
      is_m0_regdest        <= grant1 ? r1.regdest  : r0.regdest;
    end
  end

`ifdef MEM_PIPE_ARB_STATS_EN
  logic hz_cycle;
  assign hz_cycle = (req0_valid && hazard0) || (req1_valid && hazard1);

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_hazard <= '0;
    end else begin
      if (grant0   && (stat_grant0 != '1)) stat_grant0 <= stat_grant0 + 32'd1;
      if (grant1   && (stat_grant1 != '1)) stat_grant1 <= stat_grant1 + 32'd1;
      if (hz_cycle && (stat_hazard != '1)) stat_hazard <= stat_hazard + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_pipe_arbiter.sv
// Directed self-checking bench for mem_pipe_arbiter (default build, no stats).
module tb_mem_pipe_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_readmem, req0_writemem, req0_writereg;
  logic [31:0] req0_rega, req0_regdestv, req0_imedext;
  logic [4:0]  req0_regdest, req0_srca, req0_srcv;
  logic        req1_valid, req1_ready, req1_readmem, req1_writemem, req1_writereg;
  logic [31:0] req1_rega, req1_regdestv, req1_imedext;
  logic [4:0]  req1_regdest, req1_srca, req1_srcv;
  logic [1:0]  is_m0_functionalunit;
  logic        is_m0_readmem, is_m0_writemem, is_m0_writereg;
  logic [31:0] is_m0_rega, is_m0_regdestv, is_m0_imedext;
  logic [4:0]  is_m0_regdest;
  logic        flush, flush_done, busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_pipe_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_readmem(req0_readmem),
    .req0_writemem(req0_writemem), .req0_writereg(req0_writereg), .req0_rega(req0_rega),
    .req0_regdestv(req0_regdestv), .req0_imedext(req0_imedext), .req0_regdest(req0_regdest),
    .req0_srca(req0_srca), .req0_srcv(req0_srcv),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_readmem(req1_readmem),
    .req1_writemem(req1_writemem), .req1_writereg(req1_writereg), .req1_rega(req1_rega),
    .req1_regdestv(req1_regdestv), .req1_imedext(req1_imedext), .req1_regdest(req1_regdest),
    .req1_srca(req1_srca), .req1_srcv(req1_srcv),
    .is_m0_functionalunit(is_m0_functionalunit), .is_m0_readmem(is_m0_readmem),
    .is_m0_writemem(is_m0_writemem), .is_m0_writereg(is_m0_writereg),
    .is_m0_rega(is_m0_rega), .is_m0_regdestv(is_m0_regdestv), .is_m0_imedext(is_m0_imedext),
    .is_m0_regdest(is_m0_regdest),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set0(input logic v, rd, wm, wr, input logic [31:0] a, dv, im,
                      input logic [4:0] dst, sa, sv);
    req0_valid = v; req0_readmem = rd; req0_writemem = wm; req0_writereg = wr;
    req0_rega = a; req0_regdestv = dv; req0_imedext = im;
    req0_regdest = dst; req0_srca = sa; req0_srcv = sv;
  endtask

  task automatic set1(input logic v, rd, wm, wr, input logic [31:0] a, dv, im,
                      input logic [4:0] dst, sa, sv);
    req1_valid = v; req1_readmem = rd; req1_writemem = wm; req1_writereg = wr;
    req1_rega = a; req1_regdestv = dv; req1_imedext = im;
    req1_regdest = dst; req1_srca = sa; req1_srcv = sv;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    set0(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (is_m0_functionalunit !== 2'd0 || busy !== 1'b0 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0 || flush_done !== 1'b0 || is_m0_rega !== 32'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got fu=%0d busy=%0b rdy=%0b%0b fd=%0b rega=%h exp all 0",
                 i, is_m0_functionalunit, busy, req0_ready, req1_ready, flush_done, is_m0_rega);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_a;
    set0(1, 1, 0, 1, 32'hA0, 0, 0, 5'd1, 5'd2, 5'd0);
    set1(1, 1, 0, 1, 32'hB1, 0, 0, 5'd3, 5'd4, 5'd0);
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL rr_grant cyc=%0d got rdy0=%0b rdy1=%0b exp rdy0=%0b", i,
                 req0_ready, req1_ready, (i % 2 == 0));
      end
      exp_a = (i % 2 == 0) ? 32'hA0 : 32'hB1;
      step();
      checks++;
      if (is_m0_rega !== exp_a || is_m0_functionalunit !== 2'd2) begin
        failures++;
        $display("FAIL rr_issue cyc=%0d got rega=%h fu=%0d exp rega=%h fu=2", i,
                 is_m0_rega, is_m0_functionalunit, exp_a);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    checks++;
    if (is_m0_functionalunit !== 2'd0 || is_m0_readmem !== 1'b0) begin
      failures++;
      $display("FAIL rr_bubble got fu=%0d rd=%0b exp 0", is_m0_functionalunit, is_m0_readmem);
    end
    drain(5);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_busy_clear got %0b exp 0", busy);
    end
  endtask

  task automatic test_load_use();
    set0(1, 1, 0, 1, 32'h10, 0, 32'd4, 5'd5, 5'd0, 5'd0);
    settle();
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL lu_grant_load got %0b exp 1", req0_ready);
    end
    step();
    checks++;
    if (is_m0_regdest !== 5'd5 || is_m0_rega !== 32'h10 || is_m0_imedext !== 32'd4 ||
        is_m0_readmem !== 1'b1 || is_m0_functionalunit !== 2'd2) begin
      failures++;
      $display("FAIL lu_issue got dst=%0d rega=%h imm=%h rd=%0b fu=%0d exp 5 10 4 1 2",
               is_m0_regdest, is_m0_rega, is_m0_imedext, is_m0_readmem, is_m0_functionalunit);
    end
    req0_valid = 1'b0;
    set1(1, 1, 0, 1, 32'h20, 0, 0, 5'd6, 5'd5, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      settle();
      checks++;
      if (req1_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL lu_hold t+%0d got rdy1=%0b busy=%0b exp 0 1", k, req1_ready, busy);
      end
      step();
    end
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL lu_release t+6 got %0b exp 1", req1_ready);
    end
    step();
    checks++;
    if (is_m0_regdest !== 5'd6 || is_m0_rega !== 32'h20) begin
      failures++;
      $display("FAIL lu_dep_issue got dst=%0d rega=%h exp 6 20", is_m0_regdest, is_m0_rega);
    end
    req1_valid = 1'b0;
    drain(6);
  endtask

  task automatic test_store_hazard();
    set0(1, 1, 0, 1, 32'h30, 0, 0, 5'd7, 5'd0, 5'd0);
    settle(); step();
    req0_valid = 1'b0;
    set1(1, 0, 1, 0, 32'h40, 32'h55, 0, 5'd0, 5'd3, 5'd7);
    for (int k = 1; k <= 2; k++) begin
      settle();
      checks++;
      if (req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL st_hold_srcv t+%0d got %0b exp 0", k, req1_ready);
      end
      step();
    end
    // srcv only matters for stores
    req1_writemem = 1'b0;
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL st_nonstore_srcv got %0b exp 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    drain(6);
    set0(1, 1, 0, 1, 32'h30, 0, 0, 5'd0, 5'd0, 5'd0);
    settle(); step();
    req0_valid = 1'b0;
    set1(1, 0, 1, 0, 32'h40, 32'h66, 0, 5'd0, 5'd3, 5'd0);
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL st_r0_nohazard got %0b exp 1", req1_ready);
    end
    step();
    checks++;
    if (is_m0_writemem !== 1'b1 || is_m0_regdestv !== 32'h66) begin
      failures++;
      $display("FAIL st_r0_issue got wm=%0b dv=%h exp 1 66", is_m0_writemem, is_m0_regdestv);
    end
    req1_valid = 1'b0;
    drain(6);
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      set0(1, 1, 0, 1, 32'h100 + c, 0, 0, 5'(8 + c), 5'd0, 5'd0);
      settle();
      checks++;
      if (req0_ready !== 1'b1) begin
        failures++;
        $display("FAIL fl_fill c%0d got %0b exp 1", c, req0_ready);
      end
      step();
    end
    set1(1, 1, 0, 1, 32'h200, 0, 0, 5'd20, 5'd0, 5'd0);
    flush = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL fl_busy got %0b exp 1", busy);
    end
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) settle();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || flush_done !== (j == 5)) begin
        failures++;
        $display("FAIL fl_drain c%0d got rdy=%0b%0b fd=%0b exp rdy=00 fd=%0b", 3 + j,
                 req0_ready, req1_ready, flush_done, (j == 5));
      end
      step();
    end
    flush = 1'b0;
    settle();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL fl_exit_cycle got rdy=%0b%0b exp 00", req0_ready, req1_ready);
    end
    step();
    settle();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL fl_resume got rdy=%0b%0b exp 01", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(6);
  endtask

  task automatic test_reset_midflight();
    set0(1, 1, 0, 1, 32'h300, 0, 0, 5'd11, 5'd0, 5'd0);
    settle(); step();
    set0(1, 1, 0, 1, 32'h304, 0, 0, 5'd12, 5'd0, 5'd0);
    settle(); step();
    req0_valid = 1'b0;
    set1(1, 1, 0, 1, 32'h400, 0, 0, 5'd13, 5'd11, 5'd0);
    settle();
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_blocked got %0b exp 0", req1_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || is_m0_functionalunit !== 2'd0 || is_m0_rega !== 32'd0 ||
        is_m0_regdest !== 5'd0 || is_m0_readmem !== 1'b0 || is_m0_writereg !== 1'b0) begin
      failures++;
      $display("FAIL rm_cleared got busy=%0b fu=%0d rega=%h dst=%0d rd=%0b wr=%0b exp all 0",
               busy, is_m0_functionalunit, is_m0_rega, is_m0_regdest, is_m0_readmem, is_m0_writereg);
    end
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_dep_grant got %0b exp 1", req1_ready);
    end
    step();
    checks++;
    if (is_m0_functionalunit !== 2'd2 || is_m0_regdest !== 5'd13) begin
      failures++;
      $display("FAIL rm_dep_issue got fu=%0d dst=%0d exp 2 13", is_m0_functionalunit, is_m0_regdest);
    end
    req1_valid = 1'b0;
    drain(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_load_use();
    test_store_hazard();
    test_flush();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
